// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_WORDS = 16;
  localparam int OFFSET_W   = 6;

  localparam logic [2:0] KSEG1_SEG  = 3'b101;
  localparam logic [3:0] BURST_LINE = 4'b1111;
  localparam logic [3:0] BURST_WORD = 4'b0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOOKUP    = 3'd1;
  localparam state_t ST_MISS_REQ  = 3'd2;
  localparam state_t ST_MISS_WAIT = 3'd3;
  localparam state_t ST_RESP      = 3'd4;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// single-cycle full-line write, and flash-clear of every valid bit.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_W = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INDEX_W-1:0]             rd_index,
  output logic                           rd_valid,
  output logic [31-OFFSET_W-INDEX_W:0]   rd_tag,
  output logic [LINE_WORDS*32-1:0]       rd_line,
  input  logic                           wr_en,
  input  logic [INDEX_W-1:0]             wr_index,
  input  logic [31-OFFSET_W-INDEX_W:0]   wr_tag,
  input  logic [LINE_WORDS*32-1:0]       wr_line,
  input  logic                           clear
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 32 - OFFSET_W - INDEX_W;

  logic [LINES-1:0]           valid_reg;
  logic [LINES-1:0]           wr_sel;
  logic [TAG_W-1:0]           tag_mem  [LINES];
  logic [LINE_WORDS*32-1:0]   data_mem [LINES];

  assign wr_sel = wr_en ? (LINES'(1) << wr_index) : '0;

  // Clear has priority so a flash invalidate can never be undone by a fill.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        valid_reg[gi] <= 1'b0;
      end else if (wr_sel[gi]) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with 64 B lines and kseg1 bypass.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_direct
  import icache_pkg::*;
#(
  parameter int INDEX_W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic [31:0]  cpu_addr,
  output logic         cpu_addr_ok,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_data_ok,
  input  logic         inv,
  output logic         mem_req,
  output logic [3:0]   mem_burst,
  output logic [31:0]  mem_addr,
  input  logic [511:0] mem_rdata,
  input  logic         mem_addr_ok,
  input  logic         mem_data_ok
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int TAG_W = 32 - OFFSET_W - INDEX_W;

  state_t              state_reg, state_next;
  logic [31:2]         addr_reg;
  logic                inv_pend_reg;
  logic [31:0]         word_reg;

  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic [3:0]          word_sel;
  logic                uncached;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_WORDS*32-1:0] rd_line;
  logic [31:0]         line_words [LINE_WORDS];
  logic [31:0]         mem_words  [LINE_WORDS];
  logic                lookup_hit;
  logic                can_accept;
  logic                take;
  logic                fill_en;
  logic                inv_clear;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  assign index    = addr_reg[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag      = addr_reg[31:OFFSET_W+INDEX_W];
  assign word_sel = addr_reg[OFFSET_W-1:2];
  assign uncached = (addr_reg[31:29] == KSEG1_SEG);

  // Word 0 of a line sits in the most significant slot of the burst.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
    assign line_words[gi] = rd_line[(LINE_WORDS-gi)*32-1 -: 32];
    assign mem_words[gi]  = mem_rdata[(LINE_WORDS-gi)*32-1 -: 32];
  end

  assign fill_en   = (state_reg == ST_MISS_WAIT) && mem_data_ok && !uncached;
  assign inv_clear = (state_reg == ST_IDLE) && (inv || inv_pend_reg);

  icache_line_store #(.INDEX_W(INDEX_W)) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_en),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_line  (mem_rdata),
    .clear    (inv_clear)
  );

  assign lookup_hit  = (state_reg == ST_LOOKUP) && rd_valid && (rd_tag == tag) && !uncached;
  assign can_accept  = !inv && !inv_pend_reg;
  assign cpu_addr_ok = ((state_reg == ST_IDLE) || lookup_hit) && can_accept;
  assign take        = cpu_req && cpu_addr_ok;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (take) state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lookup_hit) state_next = take ? ST_LOOKUP : ST_IDLE;
        else            state_next = ST_MISS_REQ;
      end
      ST_MISS_REQ:  if (mem_addr_ok) state_next = ST_MISS_WAIT;
      ST_MISS_WAIT: if (mem_data_ok) state_next = ST_RESP;
      ST_RESP:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      inv_pend_reg <= 1'b0;
      word_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (take) addr_reg <= cpu_addr[31:2];
      // The pending flag is consumed by the flash clear on the first IDLE cycle.
      inv_pend_reg <= (state_reg == ST_IDLE) ? 1'b0 : (inv_pend_reg || inv);
      if ((state_reg == ST_MISS_WAIT) && mem_data_ok) begin
        word_reg <= uncached ? mem_rdata[31:0] : mem_words[word_sel];
      end
    end
  end

  assign mem_req   = (state_reg == ST_MISS_REQ);
  assign mem_addr  = !mem_req ? 32'h0 :
                     uncached ? {addr_reg, 2'b00} :
                                {addr_reg[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign mem_burst = !mem_req ? 4'h0 : (uncached ? BURST_WORD : BURST_LINE);

  assign cpu_data_ok = lookup_hit || (state_reg == ST_RESP);
  assign cpu_rdata   = lookup_hit              ? line_words[word_sel] :
                       (state_reg == ST_RESP)  ? word_reg : 32'h0;

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) hit_cnt <= hit_cnt + 32'd1;
      if ((state_reg == ST_LOOKUP) && !lookup_hit) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct against an address-level cache model and a
// behavioural bridge; also checks the counters when ICACHE_PERF_EN is defined.
module tb_icache_direct;

  logic         clk = 1'b0;
  logic         rst, cpu_req, inv, mem_addr_ok, mem_data_ok;
  logic [31:0]  cpu_addr;
  logic [511:0] mem_rdata;
  logic         cpu_addr_ok, cpu_data_ok, mem_req;
  logic [31:0]  cpu_rdata, mem_addr;
  logic [3:0]   mem_burst;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  icache_direct dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_addr_ok (cpu_addr_ok),
    .cpu_rdata   (cpu_rdata),
    .cpu_data_ok (cpu_data_ok),
    .inv         (inv),
    .mem_req     (mem_req),
    .mem_burst   (mem_burst),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; int due; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] burst; } mreq_t;

  int checks = 0;
  int failures = 0;
  int iter = 0;

  logic [31:0] plan_q[$];
  resp_t       exp_q[$];
  mreq_t       mexp_q[$];
  int          hs_log[$];

  bit          m_valid [128];
  logic [18:0] m_tag   [128];
  int          hits_m = 0, misses_m = 0, mem_req_cnt = 0;

  int          b_state = 0, b_cnt = 0, force_hold = -1;
  logic [31:0] b_addr;
  logic [3:0]  b_burst;
  int          gap = 0;
  bit          dir_mode = 1, inv_at_wait = 0, rst_at_wait = 0, post_rst = 0;
  int          inv_watch = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, iter);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h9FC00004) return 32'h24080001;
    return (w * 32'h9E3779B1) ^ {w[15:0], w[31:16]} ^ 32'h13572468;
  endfunction

  function automatic logic [511:0] build_line(input logic [31:0] a, input logic [3:0] burst);
    logic [511:0] d;
    d = {16{$urandom()}};
    if (burst == 4'b1111) begin
      for (int i = 0; i < 16; i++) d[511-32*i -: 32] = mem_word({a[31:6], 6'b0} + 32'(4*i));
    end else begin
      d[31:0] = mem_word(a);
    end
    return d;
  endfunction

  task automatic model_inv();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_inv();
    exp_q.delete();
    mexp_q.delete();
    b_state = 0;
    hits_m = 0;
    misses_m = 0;
  endtask

  // A fetch hits iff its 64 B line was filled and not since evicted or invalidated.
  task automatic predict(input logic [31:0] a);
    bit unc, hit;
    int idx;
    resp_t r;
    mreq_t m;
    unc = (a[31:29] == 3'b101);
    idx = int'(a[12:6]);
    hit = !unc && m_valid[idx] && (m_tag[idx] == a[31:13]);
    hs_log.push_back(iter);
    r.word = mem_word(a);
    if (hit) begin
      r.due = iter + 1;
      hits_m++;
    end else begin
      r.due = -1;
      misses_m++;
      m.addr  = unc ? {a[31:2], 2'b00} : {a[31:6], 6'b0};
      m.burst = unc ? 4'b0000 : 4'b1111;
      mexp_q.push_back(m);
      if (!unc) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[31:13];
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic step();
    bit skip, popped, exp_ok;
    mreq_t m;
    skip = 0;
    popped = 0;
    @(negedge clk);
    rst = 1'b0;
    inv = 1'b0;
    mem_addr_ok = (b_state == 1 && b_cnt == 0);
    mem_data_ok = 1'b0;
    mem_rdata = {16{$urandom()}};
    if (b_state == 2 && b_cnt == 0) begin
      mem_data_ok = 1'b1;
      mem_rdata = build_line(b_addr, b_burst);
    end else if (b_state != 2 && $urandom_range(0, 15) == 0) begin
      mem_data_ok = 1'b1;
    end
    if (rst_at_wait && b_state == 2) begin
      rst = 1'b1; rst_at_wait = 0; skip = 1; post_rst = 1;
      model_reset();
    end else if (inv_at_wait && b_state == 2) begin
      inv = 1'b1; inv_at_wait = 0; inv_watch = 1;
      model_inv();
    end else if (!dir_mode && $urandom_range(0, 80) == 0) begin
      inv = 1'b1;
      model_inv();
    end
    cpu_req  = !skip && plan_q.size() > 0 && gap == 0;
    cpu_addr = cpu_req ? plan_q[0] : $urandom();
    #1;
    if (!skip) begin
      if (post_rst) begin
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_addr_ok", 32'(cpu_addr_ok), 32'h1);
        post_rst = 0;
      end
      exp_ok = exp_q.size() > 0 && exp_q[0].due == iter;
      chk("data_ok", 32'(cpu_data_ok), 32'(exp_ok));
      if (exp_ok) begin
        chk("rdata", cpu_rdata, exp_q[0].word);
        exp_q.delete(0);
        popped = 1;
      end else begin
        chk("rdata_idle", cpu_rdata, 32'h0);
      end
      case (inv_watch)
        1: begin chk("inv_block", 32'(cpu_addr_ok), 32'h0); if (popped) inv_watch = 2; end
        2: begin chk("inv_block_idle", 32'(cpu_addr_ok), 32'h0); inv_watch = 3; end
        3: begin chk("inv_release", 32'(cpu_addr_ok), 32'h1); inv_watch = 0; end
        default: ;
      endcase
      if (cpu_req && cpu_addr_ok) begin
        predict(plan_q.pop_front());
        gap = dir_mode ? 0 : ($urandom_range(0, 1) == 0 ? 0 : int'($urandom_range(1, 3)));
      end
      case (b_state)
        0: if (mem_req) begin
          mem_req_cnt++;
          if (mexp_q.size() == 0) begin
            chk("mem_req_unexpected", 32'(mem_req), 32'h0);
          end else begin
            m = mexp_q.pop_front();
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_burst", 32'(mem_burst), 32'(m.burst));
          end
          b_addr  = mem_addr;
          b_burst = mem_burst;
          b_cnt   = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
          force_hold = -1;
          b_state = 1;
        end
        1: begin
          chk("hold_req", 32'(mem_req), 32'h1);
          chk("hold_addr", mem_addr, b_addr);
          chk("hold_burst", 32'(mem_burst), 32'(b_burst));
          if (mem_addr_ok) begin
            b_state = 2;
            b_cnt = int'($urandom_range(0, 3));
          end else begin
            b_cnt--;
          end
        end
        default: begin
          chk("req_drop", 32'(mem_req), 32'h0);
          if (mem_data_ok) begin
            if (exp_q.size() > 0) exp_q[exp_q.size()-1].due = iter + 1;
            b_state = 0;
          end else begin
            b_cnt--;
          end
        end
      endcase
    end
    if (gap > 0) gap--;
    iter++;
  endtask

  task automatic run_phase(input int budget);
    int n;
    n = 0;
    while ((plan_q.size() > 0 || exp_q.size() > 0 || b_state != 0 || inv_watch != 0 || post_rst)
           && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(plan_q.size() + exp_q.size()), 32'h0);
    plan_q.delete();
    exp_q.delete();
  endtask

  int base;
  logic [31:0] a;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_burst", 32'(mem_burst), 32'h0);
    chk("reset_data_ok", 32'(cpu_data_ok), 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    chk("reset_addr_ok", 32'(cpu_addr_ok), 32'h1);

    // Cold line fill then two back-to-back hits in the same line.
    hs_log.delete();
    base = mem_req_cnt;
    plan_q = '{32'h9FC00004, 32'h9FC00008, 32'h9FC0000C};
    run_phase(200);
    chk("cold_refills", 32'(mem_req_cnt - base), 32'd1);
    if (hs_log.size() == 3) chk("b2b_gap", 32'(hs_log[2] - hs_log[1]), 32'd1);
    else chk("b2b_handshakes", 32'(hs_log.size()), 32'd3);

    // Uncached fetches never fill.
    base = mem_req_cnt;
    plan_q = '{32'hBFC00000, 32'hBFC00000};
    run_phase(200);
    chk("uncached_reqs", 32'(mem_req_cnt - base), 32'd2);

    // Same-index eviction.
    base = mem_req_cnt;
    plan_q = '{32'h80000000, 32'h80002000, 32'h80000000};
    run_phase(300);
    chk("evict_refills", 32'(mem_req_cnt - base), 32'd3);

    // Slow bridge acceptance.
    force_hold = 4;
    plan_q = '{32'h80004040};
    run_phase(200);

    // Invalidate while a refill is in flight.
    base = mem_req_cnt;
    inv_at_wait = 1;
    plan_q = '{32'h80010000, 32'h80010000};
    run_phase(300);
    chk("inv_refills", 32'(mem_req_cnt - base), 32'd2);

    // Randomized traffic with conflicting lines, kseg1 and stray invalidates.
    dir_mode = 0;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6:
          a = 32'h80000000 | ($urandom_range(0, 3) << 13) | ($urandom_range(0, 7) << 6)
              | ($urandom_range(0, 15) << 2);
        7, 8:    a = 32'h9FC00000 | ($urandom_range(0, 31) << 2);
        default: a = 32'hA0001000 | ($urandom_range(0, 15) << 2);
      endcase
      plan_q.push_back(a);
    end
    run_phase(20000);
    dir_mode = 1;
    gap = 0;

    // Reset during a refill drops it and empties the cache.
    plan_q = '{32'h80000100, 32'h80000104};
    run_phase(200);
    rst_at_wait = 1;
    plan_q = '{32'h80020100};
    run_phase(200);
    base = mem_req_cnt;
    plan_q = '{32'h80000104};
    run_phase(200);
    chk("post_reset_miss", 32'(mem_req_cnt - base), 32'd1);

`ifdef ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt, 32'(hits_m));
    chk("miss_cnt", miss_cnt, 32'(misses_m));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
